// File: rtl/mlp_weight_loader.sv
// Streams weight words into region-addressed {sel,u,v} writes; one-cycle in-to-out latency.
// Backpressure: s_ready drops whenever a held output beat is not being taken.
module mlp_weight_loader #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4,
  parameter int U_W    = 8,
  parameter int V_W    = 8,
  parameter int N_REG  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [SEL_W-1:0]          cfg_sel,
  input  logic [U_W:0]              cfg_u_cnt,
  input  logic [V_W:0]              cfg_v_cnt,
  input  logic                      burst_start,
  input  logic [SEL_W-1:0]          burst_sel,
  input  logic                      abort,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic [SEL_W+U_W+V_W-1:0]  m_addr,
  output logic                      m_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [U_W+V_W:0]          beat_cnt
);

  localparam int A_W = SEL_W + U_W + V_W;
  localparam int B_W = U_W + V_W + 1;
  localparam logic [SEL_W:0] NREG_L = (SEL_W+1)'(N_REG);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t r_state, w_next;

  // Sized to the full select range so out-of-range entries read back as zero.
  logic [U_W:0]        r_du [2**SEL_W];
  logic [V_W:0]        r_dv [2**SEL_W];

  logic [SEL_W-1:0]    r_sel;
  logic [U_W-1:0]      r_u;
  logic [V_W-1:0]      r_v;
  logic [U_W:0]        r_ucnt;
  logic [V_W:0]        r_vcnt;
  logic [B_W-1:0]      r_beat;
  logic                r_m_valid;
  logic                r_m_last;
  logic [DATA_W-1:0]   r_m_data;
  logic [A_W-1:0]      r_m_addr;
  logic                r_done;
  logic                r_err;

  logic                w_idle;
  logic                w_sel_ok;
  logic                w_cfg_ok;
  logic [U_W:0]        w_du;
  logic [V_W:0]        w_dv;
  logic                w_start_ok;
  logic                w_s_hs;
  logic                w_m_hs;
  logic                w_v_end;
  logic                w_u_end;
  logic                w_last_in;
  logic                w_abort;

  assign w_idle     = (r_state == S_IDLE);
  assign w_sel_ok   = ({1'b0, burst_sel} < NREG_L);
  assign w_cfg_ok   = cfg_we && w_idle && ({1'b0, cfg_sel} < NREG_L);
  assign w_du       = r_du[burst_sel];
  assign w_dv       = r_dv[burst_sel];
  assign w_start_ok = burst_start && w_idle && w_sel_ok && (w_du != '0) && (w_dv != '0);
  assign w_abort    = abort && !w_idle;

  assign s_ready    = (r_state == S_RUN) && (!r_m_valid || m_ready);
  assign w_s_hs     = s_valid && s_ready;
  assign w_m_hs     = r_m_valid && m_ready;
  assign w_v_end    = ({1'b0, r_v} == (r_vcnt - 1'b1));
  assign w_u_end    = ({1'b0, r_u} == (r_ucnt - 1'b1));
  assign w_last_in  = w_u_end && w_v_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_RUN;
      S_RUN: begin
        if (abort)                      w_next = S_IDLE;
        else if (w_s_hs && w_last_in)   w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                      w_next = S_IDLE;
        else if (w_m_hs && r_m_last)    w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**SEL_W; i++) begin
        r_du[i] <= '0;
        r_dv[i] <= '0;
      end
    end else if (w_cfg_ok) begin
      r_du[cfg_sel] <= cfg_u_cnt;
      r_dv[cfg_sel] <= cfg_v_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= '0;
      r_u       <= '0;
      r_v       <= '0;
      r_ucnt    <= '0;
      r_vcnt    <= '0;
      r_beat    <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_m_addr  <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err  <= burst_start && w_idle && !w_start_ok;
      r_done <= (r_state == S_DRAIN) && !abort && w_m_hs && r_m_last;
      if (w_start_ok) begin
        r_sel  <= burst_sel;
        r_u    <= '0;
        r_v    <= '0;
        r_beat <= '0;
        r_ucnt <= w_du;
        r_vcnt <= w_dv;
      end
      // Abort wins over any handshake seen in the same cycle.
      if (w_abort) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end else if (w_s_hs) begin
        r_m_valid <= 1'b1;
        r_m_data  <= s_data;
        r_m_addr  <= {r_sel, r_u, r_v};
        r_m_last  <= w_last_in;
        r_beat    <= r_beat + 1'b1;
        if (w_v_end) begin
          r_v <= '0;
          r_u <= r_u + 1'b1;
        end else begin
          r_v <= r_v + 1'b1;
        end
      end else if (w_m_hs) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_addr   = r_m_addr;
  assign m_last   = r_m_last;
  assign busy     = !w_idle;
  assign done     = r_done;
  assign err      = r_err;
  assign beat_cnt = r_beat;

endmodule

// File: tb/tb_mlp_weight_loader.sv
// Directed + randomized bench for mlp_weight_loader against a beat-index reference model.
module tb_mlp_weight_loader;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int U_W    = 8;
  localparam int V_W    = 8;
  localparam int N_REG  = 6;
  localparam int A_W    = SEL_W + U_W + V_W;
  localparam int B_W    = U_W + V_W + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_sel;
  logic [U_W:0]      cfg_u_cnt;
  logic [V_W:0]      cfg_v_cnt;
  logic              burst_start;
  logic [SEL_W-1:0]  burst_sel;
  logic              abort;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [A_W-1:0]    m_addr;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              err;
  logic [B_W-1:0]    beat_cnt;

  mlp_weight_loader #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .U_W(U_W), .V_W(V_W), .N_REG(N_REG)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_u_cnt(cfg_u_cnt), .cfg_v_cnt(cfg_v_cnt),
    .burst_start(burst_start), .burst_sel(burst_sel), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr), .m_last(m_last),
    .busy(busy), .done(done), .err(err), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [A_W-1:0]    addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  int                n_chk = 0;
  int                n_err = 0;
  int                du[16];
  int                dv[16];
  bit                m_idle;
  int                cur_sel, cur_u, cur_v;
  int                exp_beats, n_in, n_out;
  bit                exp_done, exp_err;
  bit                stall_prev;
  logic [A_W-1:0]    st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_last;
  logic [A_W-1:0]    last_addr_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; exp_q.delete(); exp_beats = 0; n_in = 0; n_out = 0;
    exp_done = 0; exp_err = 0; stall_prev = 0;
    for (int i = 0; i < 16; i++) begin du[i] = 0; dv[i] = 0; end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    bit    nd, ne, got;
    bit    exp_srdy;
    beat_t b;
    int    k;
    @(negedge clk);
    exp_srdy = !m_idle && (exp_beats < cur_u * cur_v) && (!m_valid || m_ready);
    chk("busy", busy, !m_idle);
    chk("done", done, exp_done);
    chk("err", err, exp_err);
    chk("beat_cnt", beat_cnt, exp_beats);
    chk("s_ready", s_ready, exp_srdy);
    if (stall_prev) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_addr", m_addr, st_addr);
      chk("stall_data", m_data, st_data);
      chk("stall_last", m_last, st_last);
    end
    nd = 0; ne = 0; got = 0;
    if (!(abort && !m_idle) && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_q", exp_q.size(), 1);
      end else begin
        b = exp_q.pop_front();
        got = 1;
        chk("beat_addr", m_addr, b.addr);
        chk("beat_data", m_data, b.data);
        chk("beat_last", m_last, b.last);
        n_out++;
        last_addr_seen = m_addr;
      end
    end
    if (!m_idle) begin
      if (abort) begin
        m_idle = 1;
        exp_q.delete();
      end else begin
        if (got && b.last) begin m_idle = 1; nd = 1; end
        if (s_valid && s_ready) begin
          k = exp_beats;
          b.addr = A_W'((cur_sel << (U_W + V_W)) | ((k / cur_v) << V_W) | (k % cur_v));
          b.data = s_data;
          b.last = (k == cur_u * cur_v - 1);
          exp_q.push_back(b);
          exp_beats++;
          n_in++;
        end
      end
    end else begin
      if (burst_start) begin
        if (burst_sel < N_REG && du[burst_sel] != 0 && dv[burst_sel] != 0) begin
          m_idle = 0; cur_sel = burst_sel; cur_u = du[burst_sel]; cur_v = dv[burst_sel];
          exp_beats = 0; n_in = 0; n_out = 0;
        end else begin
          ne = 1;
        end
      end
      if (cfg_we && cfg_sel < N_REG) begin
        du[cfg_sel] = cfg_u_cnt;
        dv[cfg_sel] = cfg_v_cnt;
      end
    end
    stall_prev = m_valid && !m_ready && !abort;
    st_addr = m_addr; st_data = m_data; st_last = m_last;
    exp_done = nd;
    exp_err  = ne;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int sel, input int u, input int v);
    cfg_we = 1; cfg_sel = SEL_W'(sel); cfg_u_cnt = (U_W+1)'(u); cfg_v_cnt = (V_W+1)'(v);
    step();
    cfg_we = 0;
  endtask

  task automatic do_start(input int sel);
    burst_start = 1; burst_sel = SEL_W'(sel);
    step();
    burst_start = 0;
  endtask

  task automatic idle(input int n);
    s_valid = 0; m_ready = 0;
    repeat (n) step();
  endtask

  task automatic run(input int vpct, input int rpct, input int stop_after, input int budget);
    int cyc = 0;
    while (!m_idle && (stop_after < 0 || n_in < stop_after) && cyc < budget) begin
      s_valid = ($urandom_range(0, 99) < vpct);
      m_ready = ($urandom_range(0, 99) < rpct);
      s_data  = $urandom;
      step();
      cyc++;
    end
    s_valid = 0; m_ready = 0;
    chk("run_within_budget", cyc < budget, 1);
  endtask

  initial begin
    rst = 1; cfg_we = 0; cfg_sel = '0; cfg_u_cnt = '0; cfg_v_cnt = '0;
    burst_start = 0; burst_sel = '0; abort = 0; s_valid = 0; s_data = '0; m_ready = 0;
    cur_sel = 0; cur_u = 1; cur_v = 1; last_addr_seen = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    #2 rst = 0;
    @(posedge clk); #1;

    // Small burst: four units of one word each, full throughput.
    do_cfg(1, 4, 1);
    do_start(1);
    run(100, 100, -1, 100);
    idle(2);
    chk("b1_beats", n_out, 4);
    chk("b1_beat_cnt", beat_cnt, 4);
    chk("b1_last_addr", last_addr_seen, 20'h10300);

    // Odd-sized region with random valid/ready; a start while busy must be ignored.
    do_cfg(0, 2, 63);
    do_start(0);
    do_start(1);
    run(70, 50, -1, 3000);
    idle(2);
    chk("b0_beats", n_out, 126);
    chk("b0_last_addr", last_addr_seen, 20'h0013E);

    // Invalid starts: out-of-range select (even after a cfg attempt) and unwritten region.
    do_cfg(7, 1, 1);
    do_start(7);
    idle(1);
    do_start(3);
    idle(2);

    // Large burst aborted after 10 beats; cfg during the burst must not land.
    do_cfg(5, 256, 256);
    do_start(5);
    do_cfg(3, 5, 5);
    run(100, 60, 10, 300);
    abort = 1; s_valid = 0; m_ready = 0;
    step();
    abort = 0;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    idle(2);
    do_start(3);
    idle(1);

    // Restart the same region and stream all 65536 beats at full rate.
    do_start(5);
    run(100, 100, -1, 70000);
    idle(2);
    chk("full_beats", n_out, 65536);
    chk("full_beat_cnt", beat_cnt, 65536);
    chk("full_last_addr", last_addr_seen, 20'h5FFFF);

    // Asynchronous reset while an output beat is held.
    do_cfg(2, 3, 5);
    do_start(2);
    s_valid = 1; s_data = $urandom; m_ready = 0;
    step();
    step();
    chk("pre_rst_m_valid", m_valid, 1);
    #2 rst = 1;
    #1;
    chk_zero_outputs("midrst");
    s_valid = 0;
    @(posedge clk);
    #2 rst = 0;
    model_reset();
    @(posedge clk); #1;
    do_start(2);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
